// File: rtl/frame_pattern_checker.sv
// Reads one frame back through the SDRAM controller read port, regenerates the
// expected test-image pixel and counts mismatches (first failing index kept).
module frame_pattern_checker #(
  parameter int H_DISP = 640,
  parameter int V_DISP = 480,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdram_init_done,
  input  logic        chk_start,
  input  logic [1:0]  image_sel,
  input  logic [1:0]  bank_sel,
  output logic        rd_load,
  output logic [1:0]  rd_bank,
  output logic        sys_rd,
  input  logic [15:0] sys_rdata,
  output logic        chk_busy,
  output logic        chk_done,
  output logic        chk_pass,
  output logic [18:0] err_cnt,
  output logic [18:0] first_err_addr
);

  localparam logic [10:0] X_LAST = 11'(H_DISP - 1);
  localparam logic [18:0] N_LAST = 19'(H_DISP * V_DISP - 1);
  localparam logic [2:0]  W_LAST = 3'(RD_LAT - 1);
  localparam int          BAR_W  = H_DISP / 8;

  typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, LOAD2, REQ, WAIT, CMP, DONE} state_t;

  state_t      state, state_nxt;
  logic [10:0] x, y;
  logic [18:0] addr;
  logic [2:0]  wcnt;
  logic [1:0]  img;
  logic [15:0] rdata_q;
  logic [15:0] expected;
  logic [21:0] prod;
  logic [2:0]  bar;
  logic        mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                state <= IDLE;
    else if (!sdram_init_done) state <= IDLE;
    else                       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_load   = 1'b0;
    sys_rd    = 1'b0;
    chk_done  = 1'b0;
    chk_busy  = (state != IDLE);
    case (state)
      IDLE:  if (chk_start) state_nxt = LOAD0;
      LOAD0: state_nxt = LOAD1;
      LOAD1: begin rd_load = 1'b1; state_nxt = LOAD2; end
      LOAD2: state_nxt = REQ;
      REQ:   begin sys_rd = 1'b1; state_nxt = WAIT; end
      WAIT:  if (wcnt == W_LAST) state_nxt = CMP;
      CMP:   state_nxt = (addr == N_LAST) ? DONE : REQ;
      DONE:  begin chk_done = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  // Bar index = number of bar boundaries at or left of x, so the last bar
  // also absorbs any remainder when H_DISP is not a multiple of 8.
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++)
      if (int'(x) >= k * BAR_W) bar = 3'(k);
  end

  assign prod = x * y;

  always_comb begin
    expected = 16'h0000;
    case (img)
      2'd0: expected = prod[15:0];
      2'd1:
        case (bar)
          3'd0: expected = 16'hF800;
          3'd1: expected = 16'h07E0;
          3'd2: expected = 16'h001F;
          3'd3: expected = 16'hFFFF;
          3'd4: expected = 16'h0000;
          3'd5: expected = 16'hFFE0;
          3'd6: expected = 16'hF81F;
          default: expected = 16'h07FF;
        endcase
      2'd2: expected = {5'b0, x};
      default: expected = {5'b0, y};
    endcase
  end

  assign mismatch = (rdata_q != expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0; y <= '0; addr <= '0; wcnt <= '0; img <= '0; rdata_q <= '0;
      rd_bank <= '0; err_cnt <= '0; first_err_addr <= '0; chk_pass <= 1'b0;
    end else if (!sdram_init_done) begin
      x <= '0; y <= '0; addr <= '0; wcnt <= '0; img <= '0; rdata_q <= '0;
      rd_bank <= '0; err_cnt <= '0; first_err_addr <= '0; chk_pass <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (chk_start) begin
            img            <= image_sel;
            rd_bank        <= bank_sel;
            err_cnt        <= '0;
            first_err_addr <= '0;
            chk_pass       <= 1'b0;
            x              <= '0;
            y              <= '0;
            addr           <= '0;
          end
        REQ:  wcnt <= '0;
        WAIT: begin
          wcnt <= wcnt + 3'd1;
          // read data is only guaranteed on the last wait cycle
          if (wcnt == W_LAST) rdata_q <= sys_rdata;
        end
        CMP: begin
          if (mismatch) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 19'd1;
            if (err_cnt == '0) first_err_addr <= addr;
          end
          if (addr != N_LAST) begin
            addr <= addr + 19'd1;
            if (x == X_LAST) begin
              x <= '0;
              y <= y + 11'd1;
            end else begin
              x <= x + 11'd1;
            end
          end
        end
        DONE: chk_pass <= (err_cnt == '0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_pattern_checker.sv
// Randomized bench: two checker instances (8x4 / RD_LAT 1 and 640x2 / RD_LAT 3)
// each reading from a behavioural SDRAM model; results scored by a pixel-rule model.
module tb_frame_pattern_checker;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic             rst_n;
  logic [1:0]       init, start, load, srd, busy, done, pass;
  logic [1:0][1:0]  isel, bsel, rbank;
  logic [15:0]      rdata0, rdata1;
  logic [1:0][18:0] err, fea;

  frame_pattern_checker #(.H_DISP(8), .V_DISP(4), .RD_LAT(1)) u_small (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(init[0]), .chk_start(start[0]),
    .image_sel(isel[0]), .bank_sel(bsel[0]), .rd_load(load[0]), .rd_bank(rbank[0]),
    .sys_rd(srd[0]), .sys_rdata(rdata0), .chk_busy(busy[0]), .chk_done(done[0]),
    .chk_pass(pass[0]), .err_cnt(err[0]), .first_err_addr(fea[0]));

  frame_pattern_checker #(.H_DISP(640), .V_DISP(2), .RD_LAT(3)) u_wide (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(init[1]), .chk_start(start[1]),
    .image_sel(isel[1]), .bank_sel(bsel[1]), .rd_load(load[1]), .rd_bank(rbank[1]),
    .sys_rd(srd[1]), .sys_rdata(rdata1), .chk_busy(busy[1]), .chk_done(done[1]),
    .chk_pass(pass[1]), .err_cnt(err[1]), .first_err_addr(fea[1]));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // memory contents: image mimg, optionally all FFFF, with up to 4 corrupted pixels
  int          HH[2]  = '{8, 640};
  int          NP[2]  = '{32, 1280};
  int          LAT[2] = '{1, 3};
  int          mimg[2];
  bit          allff[2];
  int          ncor[2];
  int          cidx[2][4];
  logic [15:0] cval[2][4];

  function automatic logic [15:0] bar_color(int b);
    case (b)
      0: return 16'hF800;
      1: return 16'h07E0;
      2: return 16'h001F;
      3: return 16'hFFFF;
      4: return 16'h0000;
      5: return 16'hFFE0;
      6: return 16'hF81F;
      default: return 16'h07FF;
    endcase
  endfunction

  function automatic logic [15:0] pix(int im, int n, int h);
    int px, py, b;
    px = n % h;
    py = n / h;
    case (im)
      0: return 16'((px * py) & 32'hFFFF);
      1: begin b = px / (h / 8); if (b > 7) b = 7; return bar_color(b); end
      2: return 16'(px);
      default: return 16'(py);
    endcase
  endfunction

  function automatic logic [15:0] mem_val(int i, int n);
    for (int k = 0; k < ncor[i]; k++)
      if (cidx[i][k] == n) return cval[i][k];
    if (allff[i]) return 16'hFFFF;
    return pix(mimg[i], n, HH[i]);
  endfunction

  // SDRAM read-port models; data is only valid in the single cycle RD_LAT after sys_rd
  int ra0 = 0;
  always @(posedge clk) begin
    if (load[0])     ra0 <= 0;
    else if (srd[0]) ra0 <= ra0 + 1;
    rdata0 <= srd[0] ? mem_val(0, ra0) : 16'($urandom);
  end

  int          ra1 = 0;
  logic [1:0]  v1 = '0;
  logic [15:0] d1a, d1b;
  always @(posedge clk) begin
    if (load[1])     ra1 <= 0;
    else if (srd[1]) ra1 <= ra1 + 1;
    v1     <= {v1[0], srd[1]};
    d1a    <= mem_val(1, ra1);
    d1b    <= d1a;
    rdata1 <= v1[1] ? d1b : 16'($urandom);
  end

  int nrd[2] = '{0, 0};
  int nld[2] = '{0, 0};
  int ndn[2] = '{0, 0};
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      if (srd[i])  nrd[i] <= nrd[i] + 1;
      if (load[i]) nld[i] <= nld[i] + 1;
      if (done[i]) ndn[i] <= ndn[i] + 1;
    end

  task automatic expect_frame(input int i, input int im, input int upto,
                              output int e, output int f);
    e = 0;
    f = 0;
    for (int n = 0; n < upto; n++)
      if (mem_val(i, n) != pix(im, n, HH[i])) begin
        if (e == 0) f = n;
        e++;
      end
  endtask

  // xs > 0: pulse a conflicting chk_start xs cycles into the frame
  task automatic run_frame(input int i, input int im, input int bk, input int xs);
    int e, f, r0, l0, d0, cyc, budget;
    bit to, bank_bad;
    expect_frame(i, im, NP[i], e, f);
    r0 = nrd[i]; l0 = nld[i]; d0 = ndn[i];
    budget = NP[i] * (LAT[i] + 2) + 50;
    isel[i] = 2'(im); bsel[i] = 2'(bk); start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    cyc = 0; to = 1'b1; bank_bad = 1'b0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      start[i] = 1'b0;
      if (!busy[i]) begin to = 1'b0; break; end
      if (rbank[i] != 2'(bk)) bank_bad = 1'b1;
      if (cyc == xs) begin
        isel[i] = ~2'(im); bsel[i] = ~2'(bk); start[i] = 1'b1;
      end
    end
    start[i] = 1'b0;
    chk($sformatf("timeout%0d", i), to, 0);
    chk($sformatf("rd_pulses%0d", i), nrd[i] - r0, NP[i]);
    chk($sformatf("rd_load%0d", i), nld[i] - l0, 1);
    chk($sformatf("done%0d", i), ndn[i] - d0, 1);
    chk($sformatf("bank_hold%0d", i), bank_bad, 0);
    chk($sformatf("rd_bank%0d", i), rbank[i], bk);
    chk($sformatf("err_cnt%0d", i), err[i], e);
    chk($sformatf("first_err%0d", i), fea[i], f);
    chk($sformatf("pass%0d", i), pass[i], (e == 0));
  endtask

  task automatic drop_test();
    int k, c, e, f, d0;
    bit to;
    mimg[0] = 1; allff[0] = 1'b1; ncor[0] = 0;
    expect_frame(0, 1, 10, e, f);
    isel[0] = 2'd1; bsel[0] = 2'd3; start[0] = 1'b1;
    k = 0; to = 1'b1;
    for (c = 0; c < 200; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (srd[0]) k++;
      if (k == 11) begin to = 1'b0; break; end
    end
    chk("drop_reach", to, 0);
    chk("drop_pre_err", err[0], e);
    d0 = ndn[0];
    init[0] = 1'b0;
    @(negedge clk);
    chk("drop_busy", busy[0], 0);
    chk("drop_strobes", {srd[0], load[0], done[0]}, 0);
    chk("drop_pass", pass[0], 0);
    chk("drop_err", err[0], 0);
    chk("drop_fea", fea[0], 0);
    chk("drop_bank", rbank[0], 0);
    init[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("drop_no_done", ndn[0] - d0, 0);
    allff[0] = 1'b0;
    run_frame(0, 1, 1, 0);
  endtask

  initial begin
    int im;
    rst_n = 1'b0; init = 2'b11; start = '0; isel = '0; bsel = '0;
    for (int i = 0; i < 2; i++) begin mimg[i] = 2; allff[i] = 1'b0; ncor[i] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_strobes", {busy, done, pass, srd, load}, 0);
    chk("rst_err", err, 0);
    chk("rst_fea", fea, 0);
    chk("rst_bank", rbank, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    run_frame(0, 2, 2, 0);                       // exact image 2
    allff[0] = 1'b1;
    run_frame(0, 3, 1, 0);                       // all FFFF vs image 3: 32 errors
    allff[0] = 1'b0; mimg[0] = 2;
    run_frame(0, 2, 3, 40);                      // ignored mid-frame start
    drop_test();

    for (int r = 0; r < 6; r++) begin
      mimg[0] = $urandom_range(0, 3);
      im = ($urandom % 2) ? mimg[0] : $urandom_range(0, 3);
      ncor[0] = $urandom_range(0, 3);
      for (int k = 0; k < 4; k++) begin
        cidx[0][k] = $urandom_range(0, 31);
        cval[0][k] = 16'($urandom);
      end
      run_frame(0, im, $urandom_range(0, 3), 0);
    end

    mimg[1] = 2; ncor[1] = 0;
    run_frame(1, 2, 1, 0);                       // RD_LAT 3, exact
    mimg[1] = 1; ncor[1] = 1; cidx[1][0] = 1000; cval[1][0] = 16'h1234;
    run_frame(1, 1, 0, 0);                       // bars, pixel 1000 corrupted
    mimg[1] = 0; ncor[1] = 0;
    run_frame(1, 0, 3, 0);                       // x*y exact
    ncor[1] = 1; cidx[1][0] = 1279; cval[1][0] = pix(0, 1279, 640) ^ 16'h0010;
    run_frame(1, 0, 2, 0);                       // last pixel bit flip

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
